// File: rtl/fifo_rd_chk_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_chk_pkg
// Shared definitions for the async-FIFO read-side checker:
//   - state_t     : checker FSM encodings (IDLE/RUN/DRAIN/DONE)
//   - LFSR_TAPS   : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - MAX_RD_LAT  : largest supported read latency
//   - lfsr_next() : one step of the 8-bit Fibonacci LFSR (shift left,
//                   feedback into bit 0)
// Build option: FIFO_RD_CHK_LFSR_EN (consumed by fifo_rd_pattern_gen).
// -----------------------------------------------------------------------------
package fifo_rd_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam int         MAX_RD_LAT = 4;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fifo_rd_checker_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_checker_if
// Read port of the async FIFO as seen from the read (clkb) domain.
//   rreqb  : read request from the consumer
//   rdata  : read data, valid a fixed latency after an accepted read
//   emptyb : FIFO empty flag
// Handshake: a read is accepted in every cycle where rreqb is high; the
// consumer only raises rreqb while emptyb is low, so an accepted read never
// underflows. There is no back-pressure on rdata: the word simply appears
// the configured number of cycles later and must be taken in that cycle.
// Modports: master = consumer/checker, slave = FIFO.
// -----------------------------------------------------------------------------
interface fifo_rd_checker_if #(
    parameter int DW = 8
);
    logic          rreqb;
    logic [DW-1:0] rdata;
    logic          emptyb;

    modport master (output rreqb, input rdata, input emptyb);
    modport slave  (input rreqb, output rdata, output emptyb);
endinterface

// File: rtl/fifo_rd_pattern_gen.sv
// -----------------------------------------------------------------------------
// fifo_rd_pattern_gen
// Holds the next expected read word.
//   clkb, rstnb  : clock, async active-low reset (reset value = SEED)
//   i_load       : reload SEED (takes priority over i_advance)
//   i_advance    : step to the next word of the sequence
//   o_expected   : current expected word
// Sequence: incrementing (mod 2^DW) by default; 8-bit Fibonacci LFSR when
// FIFO_RD_CHK_LFSR_EN is defined (DW must then be 8, SEED nonzero).
// -----------------------------------------------------------------------------
module fifo_rd_pattern_gen
    import fifo_rd_chk_pkg::*;
#(
    parameter int            DW   = 8,
    parameter logic [DW-1:0] SEED = {{(DW-1){1'b0}}, 1'b1}
) (
    input  logic          clkb,
    input  logic          rstnb,
    input  logic          i_load,
    input  logic          i_advance,
    output logic [DW-1:0] o_expected
);

    logic [DW-1:0] r_expected;
    logic [DW-1:0] w_next;

    always_comb begin
`ifdef FIFO_RD_CHK_LFSR_EN
        w_next = DW'(lfsr_next(8'(r_expected)));
`else
        w_next = r_expected + DW'(1);
`endif
    end

    always_ff @(posedge clkb or negedge rstnb) begin
        if (!rstnb) begin
            r_expected <= SEED;
        end else if (i_load) begin
            r_expected <= SEED;
        end else if (i_advance) begin
            r_expected <= w_next;
        end
    end

    assign o_expected = r_expected;

endmodule

// File: rtl/fifo_rd_checker.sv
// -----------------------------------------------------------------------------
// fifo_rd_checker
// Read-side traffic consumer/checker for the async FIFO (clkb domain).
// A start pulse drains NUM_WORDS words from the FIFO and compares each one
// against a locally generated expected pattern.
// Ports:
//   clkb, rstnb : read clock, async active-low reset
//   start       : 1-cycle pulse, begins a run (ignored while busy)
//   rd_if       : FIFO read port (master: rreqb out, rdata/emptyb in)
//   busy        : high in RUN and DRAIN
//   done        : high in DONE until the next start
//   mismatch    : sticky, a compare failed in the current run
//   rx_cnt      : words compared in the current run (wraps)
//   err_cnt     : mismatching words (saturates at all-ones)
//   dbg_state   : current FSM state
// Build option: FIFO_RD_CHK_LFSR_EN selects the LFSR pattern (see
// fifo_rd_pattern_gen); the writer-side generator must match.
// -----------------------------------------------------------------------------
module fifo_rd_checker
    import fifo_rd_chk_pkg::*;
#(
    parameter int            DW        = 8,
    parameter int            CNT_W     = 16,
    parameter int            NUM_WORDS = 256,
    parameter int            RD_LAT    = 1,
    parameter int            GAP       = 0,
    parameter logic [DW-1:0] SEED      = {{(DW-1){1'b0}}, 1'b1}
) (
    input  logic               clkb,
    input  logic               rstnb,
    input  logic               start,
    fifo_rd_checker_if.master  rd_if,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [CNT_W-1:0]   rx_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output state_t             dbg_state
);

    localparam logic [CNT_W-1:0] NUM_WORDS_C = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] GAP_C       = CNT_W'(GAP);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_gap_cnt;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_mismatch;
    logic [RD_LAT-1:0] r_vld;       // bit i set: a read issued i+1 cycles ago
    logic [DW-1:0]     w_expected;
    logic              w_start_ok;
    logic              w_rd_accept;
    logic              w_last_issue;
    logic              w_cmp_vld;
    logic              w_cmp_err;
    logic              w_more_in_flight;
    logic              w_busy;
    logic              w_done;

    assign w_start_ok   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_rd_accept  = (r_state == ST_RUN) & ~rd_if.emptyb &
                          (r_gap_cnt == '0) & (r_issued < NUM_WORDS_C);
    assign w_last_issue = w_rd_accept & (r_issued == LAST_IDX_C);
    assign w_cmp_vld    = r_vld[RD_LAT-1];
    assign w_cmp_err    = w_cmp_vld & (rd_if.rdata != w_expected);

    // Reads still in flight once the word at the compare stage is consumed;
    // DRAIN may leave as soon as this is empty, landing in DONE the cycle
    // after the final compare.
    always_comb begin
        w_more_in_flight = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            w_more_in_flight = w_more_in_flight | r_vld[i];
        end
    end

    always_ff @(posedge clkb or negedge rstnb) begin
        if (!rstnb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last_issue) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (!w_more_in_flight) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (start) w_next_state = ST_RUN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkb or negedge rstnb) begin
        if (!rstnb) begin
            r_issued   <= '0;
            r_gap_cnt  <= '0;
            r_rx_cnt   <= '0;
            r_err_cnt  <= '0;
            r_mismatch <= 1'b0;
            r_vld      <= '0;
        end else begin
            r_vld[0] <= w_rd_accept;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_start_ok) begin
                r_issued   <= '0;
                r_gap_cnt  <= '0;
                r_rx_cnt   <= '0;
                r_err_cnt  <= '0;
                r_mismatch <= 1'b0;
            end else begin
                if (w_rd_accept) begin
                    r_issued  <= r_issued + CNT_W'(1);
                    r_gap_cnt <= GAP_C;
                end else if (r_gap_cnt != '0) begin
                    r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                end
                if (w_cmp_vld) begin
                    r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    if (w_cmp_err) begin
                        r_mismatch <= 1'b1;
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    fifo_rd_pattern_gen #(
        .DW   (DW),
        .SEED (SEED)
    ) u_pattern_gen (
        .clkb       (clkb),
        .rstnb      (rstnb),
        .i_load     (w_start_ok),
        .i_advance  (w_cmp_vld),
        .o_expected (w_expected)
    );

    assign rd_if.rreqb = w_rd_accept;
    assign busy        = w_busy;
    assign done        = w_done;
    assign mismatch    = r_mismatch;
    assign rx_cnt      = r_rx_cnt;
    assign err_cnt     = r_err_cnt;
    assign dbg_state   = r_state;

endmodule
